// File: rtl/sprite_io_responder_if.sv
// rtl/sprite_io_responder_if.sv - CPU I/O bus between the stack-machine CPU and its I/O responder
interface sprite_io_responder_if #(
    parameter int CPU_WIDTH = 16
);
    logic [CPU_WIDTH-1:0] io_addr;
    logic                 io_write;
    logic [CPU_WIDTH-1:0] io_wr_data;
    logic [CPU_WIDTH-1:0] io_rd_data;

    modport master (output io_addr, output io_write, output io_wr_data, input io_rd_data);
    modport slave  (input io_addr, input io_write, input io_wr_data, output io_rd_data);
endinterface

// File: rtl/sprite_io_responder.sv
// rtl/sprite_io_responder.sv - LED, sprite position, frame counter registers and TX FIFO + 8N1 UART
module sprite_io_responder #(
    parameter int CPU_WIDTH    = 16,
    parameter int NUM_SPRITES  = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 217
) (
    input  logic                     clock,
    input  logic                     reset,
    sprite_io_responder_if.slave     bus,
    input  logic                     vsync_pulse,
    output logic [3:0]               led,
    output logic [NUM_SPRITES*10-1:0] sprite_x,
    output logic [NUM_SPRITES*10-1:0] sprite_y,
    output logic                     uart_tx
);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    logic       sel, wr_en, wr_status, wr_tx;
    logic [7:0] off;
    logic       unused_addr_bits;

    logic [3:0]  led_q;
    logic [15:0] frame_count_q;
    logic        frame_q, ovf_q;
    logic [9:0]  sx_q [NUM_SPRITES];
    logic [9:0]  sy_q [NUM_SPRITES];

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_full, fifo_empty, push, pop;

    uart_state_t       state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d, busy;

    assign sel              = (bus.io_addr[15:12] == 4'h4);
    assign off              = bus.io_addr[7:0];
    assign unused_addr_bits = ^bus.io_addr[11:8];
    assign wr_en            = bus.io_write & sel;
    assign wr_status        = wr_en && (off == 8'h01);
    assign wr_tx            = wr_en && (off == 8'h03);

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    // full is judged before any same-cycle pop, so a push at full is always dropped
    assign push       = wr_tx & ~fifo_full;
    assign busy       = (state_q != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            led_q         <= '0;
            frame_count_q <= '0;
            frame_q       <= 1'b0;
            ovf_q         <= 1'b0;
            for (int n = 0; n < NUM_SPRITES; n++) begin
                sx_q[n] <= '0;
                sy_q[n] <= '0;
            end
        end else begin
            if (wr_en && off == 8'h00) led_q <= bus.io_wr_data[3:0];
            if (wr_en && off == 8'h02) frame_count_q <= bus.io_wr_data[15:0];
            else if (vsync_pulse)      frame_count_q <= frame_count_q + 16'd1;
            if (vsync_pulse)                          frame_q <= 1'b1;
            else if (wr_status && bus.io_wr_data[0])  frame_q <= 1'b0;
            if (wr_tx && fifo_full)                   ovf_q <= 1'b1;
            else if (wr_status && bus.io_wr_data[4])  ovf_q <= 1'b0;
            for (int n = 0; n < NUM_SPRITES; n++) begin
                if (wr_en && off == 8'(16 + 2*n)) sx_q[n] <= bus.io_wr_data[9:0];
                if (wr_en && off == 8'(17 + 2*n)) sy_q[n] <= bus.io_wr_data[9:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= bus.io_wr_data[7:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        bus.io_rd_data = '0;
        if (sel) begin
            case (off)
                8'h00: bus.io_rd_data = CPU_WIDTH'(led_q);
                8'h01: bus.io_rd_data = CPU_WIDTH'({ovf_q, busy, fifo_empty, fifo_full, frame_q});
                8'h02: bus.io_rd_data = CPU_WIDTH'(frame_count_q);
                default: begin
                    for (int n = 0; n < NUM_SPRITES; n++) begin
                        if (off == 8'(16 + 2*n)) bus.io_rd_data = CPU_WIDTH'(sx_q[n]);
                        if (off == 8'(17 + 2*n)) bus.io_rd_data = CPU_WIDTH'(sy_q[n]);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // tx_q follows the current state one cycle later, keeping the pin glitch-free
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem[rd_ptr];
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign uart_tx = tx_q;
    assign led     = led_q;
    for (genvar n = 0; n < NUM_SPRITES; n++) begin : g_pack
        assign sprite_x[10*n +: 10] = sx_q[n];
        assign sprite_y[10*n +: 10] = sy_q[n];
    end
endmodule

// File: tb/tb_sprite_io_responder.sv
// tb/tb_sprite_io_responder.sv - randomized and directed bench for sprite_io_responder
module tb_sprite_io_responder;
    localparam int CW  = 16;
    localparam int NS  = 4;
    localparam int FD  = 8;
    localparam int CPB = 217;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            vsync_pulse = 1'b0;
    logic [3:0]      led;
    logic [NS*10-1:0] sprite_x, sprite_y;
    logic            uart_tx;

    sprite_io_responder_if #(.CPU_WIDTH(CW)) bus();

    sprite_io_responder #(.CPU_WIDTH(CW), .NUM_SPRITES(NS), .FIFO_DEPTH(FD), .CLKS_PER_BIT(CPB)) dut (
        .clock(clock), .reset(reset), .bus(bus), .vsync_pulse(vsync_pulse),
        .led(led), .sprite_x(sprite_x), .sprite_y(sprite_y), .uart_tx(uart_tx)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int frames_seen = 0;
    bit mon_en = 1'b1;

    logic [3:0]  m_led;
    logic [15:0] m_fc;
    bit          m_frame, m_ovf;
    logic [9:0]  m_sx [NS];
    logic [9:0]  m_sy [NS];
    logic [7:0]  fifo_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_led = '0; m_fc = '0; m_frame = 0; m_ovf = 0;
        for (int n = 0; n < NS; n++) begin m_sx[n] = '0; m_sy[n] = '0; end
        fifo_q.delete();
    endtask

    function automatic logic [15:0] model_read(input logic [15:0] a, input bit busy);
        logic [7:0] o;
        o = a[7:0];
        if (a[15:12] != 4'h4) return 16'h0;
        if (o == 8'h00) return {12'h0, m_led};
        if (o == 8'h01) return {11'h0, m_ovf, busy, fifo_q.size() == 0, fifo_q.size() == FD, m_frame};
        if (o == 8'h02) return m_fc;
        if (o >= 8'h10 && int'(o) < 16 + 2*NS) begin
            int n;
            n = (int'(o) - 16) / 2;
            return o[0] ? {6'h0, m_sy[n]} : {6'h0, m_sx[n]};
        end
        return 16'h0;
    endfunction

    function automatic logic [NS*10-1:0] pack_pos(input bit y);
        logic [NS*10-1:0] r;
        for (int n = 0; n < NS; n++) r[n*10 +: 10] = y ? m_sy[n] : m_sx[n];
        return r;
    endfunction

    // One bus cycle with optional write and vsync; the model applies the register rules afterwards
    task automatic bus_cycle(input bit w, input logic [15:0] a, input logic [15:0] d, input bit vs);
        logic [7:0] o;
        o = a[7:0];
        bus.io_addr = a; bus.io_wr_data = d; bus.io_write = w; vsync_pulse = vs;
        @(posedge clock); #1;
        bus.io_write = 1'b0; vsync_pulse = 1'b0;
        if (vs) begin m_fc = m_fc + 16'd1; m_frame = 1; end
        if (w && a[15:12] == 4'h4) begin
            case (o)
                8'h00: m_led = d[3:0];
                8'h01: begin
                    if (d[0] && !vs) m_frame = 0;
                    if (d[4]) m_ovf = 0;
                end
                8'h02: m_fc = d;
                8'h03: begin
                    if (fifo_q.size() < FD) fifo_q.push_back(d[7:0]);
                    else m_ovf = 1;
                end
                default: begin
                    if (o >= 8'h10 && int'(o) < 16 + 2*NS) begin
                        if (o[0]) m_sy[(int'(o) - 16) / 2] = d[9:0];
                        else      m_sx[(int'(o) - 16) / 2] = d[9:0];
                    end
                end
            endcase
        end
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        bus.io_addr = a; bus.io_write = 1'b0;
        #1;
        d = bus.io_rd_data;
    endtask

    function automatic logic [15:0] rand_addr();
        logic [7:0] o;
        logic [3:0] hi;
        case ($urandom_range(0, 5))
            0: o = 8'h00;
            1: o = 8'h01;
            2: o = 8'h02;
            3, 4: o = 8'(16 + $urandom_range(0, 15));
            default: o = 8'($urandom);
        endcase
        if (o == 8'h03) o = 8'h00;
        hi = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h4;
        return {hi, 4'($urandom), o};
    endfunction

    // Serial monitor: decodes each 8N1 frame and compares it with the next accepted byte
    initial begin : serial_monitor
        logic [7:0] got, exp;
        forever begin
            @(negedge uart_tx);
            if (!mon_en || reset) continue;
            check("byte_queued_at_start", fifo_q.size() > 0, 1);
            exp = (fifo_q.size() > 0) ? fifo_q.pop_front() : 8'h00;
            repeat (CPB/2) @(posedge clock);
            #1 check("start_bit", uart_tx, 0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clock);
                #1 got[i] = uart_tx;
            end
            repeat (CPB) @(posedge clock);
            #1 check("stop_bit", uart_tx, 1);
            check("serial_byte", got, exp);
            frames_seen++;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [15:0] s, a;
        int cnt;
        bus.io_addr = '0; bus.io_wr_data = '0; bus.io_write = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        bus_read(16'h4000, s); check("reset_led_reg", s, 16'h0000);
        bus_read(16'h4001, s); check("reset_status", s, 16'h0004);
        bus_read(16'h4002, s); check("reset_frame_count", s, 16'h0000);
        check("reset_uart_tx", uart_tx, 1);
        check("reset_led", led, 4'h0);
        check("reset_sprite_x", sprite_x, '0);

        bus_cycle(1, 16'h4000, 16'hFFFF, 0);
        check("led_out", led, 4'hF);
        bus_read(16'h4000, s); check("led_read", s, 16'h000F);
        bus_cycle(1, 16'h4013, 16'h03FF, 0);
        check("sprite1_y_out", sprite_y[19:10], 10'h3FF);
        bus_read(16'h4013, s); check("sprite1_y_read", s, 16'h03FF);
        bus_read(16'h4113, s); check("addr_11_8_ignored", s, 16'h03FF);
        bus_cycle(1, 16'h4018, 16'h0155, 0);
        bus_read(16'h4018, s); check("sprite4_out_of_range", s, 16'h0000);
        bus_read(16'h5000, s); check("unselected_read", s, 16'h0000);

        repeat (3) bus_cycle(0, 16'h4002, 16'h0000, 1);
        bus_read(16'h4002, s); check("frame_count_3", s, 16'h0003);
        bus_read(16'h4001, s); check("frame_flag_set", s[0], 1);
        bus_cycle(1, 16'h4001, 16'h0001, 1);
        bus_read(16'h4001, s); check("vsync_beats_clear", s[0], 1);
        bus_read(16'h4002, s); check("frame_count_4", s, 16'h0004);
        bus_cycle(1, 16'h4002, 16'hFFFF, 0);
        bus_cycle(0, 16'h4002, 16'h0000, 1);
        bus_read(16'h4002, s); check("frame_count_wrap", s, 16'h0000);
        bus_cycle(1, 16'h4002, 16'h1234, 1);
        bus_read(16'h4002, s); check("fc_write_beats_vsync", s, 16'h1234);
        bus_cycle(1, 16'h4001, 16'h0001, 0);
        bus_read(16'h4001, s); check("frame_clear", s, 16'h0004);

        for (int it = 0; it < 200; it++) begin
            bus_cycle($urandom_range(0, 3) != 0, rand_addr(), 16'($urandom), $urandom_range(0, 3) == 0);
            a = rand_addr();
            bus_read(a, s);
            check("rand_read", s, model_read(a, 0));
            check("rand_led", led, m_led);
            check("rand_sprite_x", sprite_x, pack_pos(0));
            check("rand_sprite_y", sprite_y, pack_pos(1));
        end

        bus_cycle(1, 16'h4003, 16'h00A5, 0);
        @(posedge clock); #1 check("tx_high_1_after_push", uart_tx, 1);
        @(posedge clock); #1 check("tx_start_2_after_push", uart_tx, 0);
        cnt = 0;
        for (int c = 0; c < 10*CPB - 2; c++) begin
            @(posedge clock); #1;
            bus_read(16'h4001, s);
            if (!s[3]) cnt++;
        end
        check("busy_whole_frame", cnt, 0);
        @(posedge clock); #1;
        bus_read(16'h4001, s); check("idle_after_10_bits", s & 16'h000E, 16'h0004);
        check("frames_after_a5", frames_seen, 1);

        bus_cycle(1, 16'h4003, 16'h0000, 0);
        cnt = 0;
        while (uart_tx && cnt < 20) begin @(posedge clock); #1; cnt++; end
        check("prior_byte_started", uart_tx, 0);
        for (int i = 1; i <= 10; i++) bus_cycle(1, 16'h4003, 16'(i), 0);
        bus_read(16'h4001, s);
        check("status_overflow", s & 16'h001E, 16'h001A);
        check("status_overflow_model", s, model_read(16'h4001, 1));
        bus_cycle(1, 16'h4001, 16'h0010, 0);
        bus_read(16'h4001, s); check("ovf_cleared", s & 16'h001E, 16'h000A);
        cnt = 0;
        while (frames_seen < 10 && cnt < 25000) begin @(posedge clock); #1; cnt++; end
        check("frames_after_overflow", frames_seen, 10);
        repeat (CPB) @(posedge clock); #1;
        bus_read(16'h4001, s); check("drained_status", s & 16'h001E, 16'h0004);

        mon_en = 1'b0;
        bus_cycle(1, 16'h4003, 16'h00F0, 0);
        bus_cycle(1, 16'h4003, 16'h0055, 0);
        repeat (4*CPB + CPB/2) @(posedge clock);
        #1 check("tx_data_bit3", uart_tx, 0);
        reset = 1'b1;
        #1 check("tx_async_reset", uart_tx, 1);
        check("led_async_reset", led, 4'h0);
        @(posedge clock); #1 reset = 1'b0;
        model_reset();
        bus_read(16'h4001, s); check("status_after_reset", s, 16'h0004);
        bus_read(16'h4002, s); check("fc_after_reset", s, 16'h0000);
        check("sprite_y_after_reset", sprite_y, '0);
        cnt = 0;
        for (int c = 0; c < 3*CPB; c++) begin
            @(posedge clock); #1;
            if (!uart_tx) cnt++;
        end
        check("no_serial_after_reset", cnt, 0);
        bus_read(16'h4001, s); check("fifo_discarded", s, 16'h0004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
